// File: rtl/dec_rv_queue.sv
// RV32/RV64 instruction decoder feeding a DEPTH-entry queue of decoded entries.
// Optional DEC_RV_QUEUE_BYPASS_EN: an empty queue shows the incoming decode combinationally.
module dec_rv_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [XLEN-1:0]          i_pc,
  input  logic [31:0]              i_instr,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [XLEN-1:0]          o_pc,
  output logic [31:0]              o_instr,
  output logic [4:0]               o_opcode,
  output logic [5:0]               o_radr1,
  output logic [5:0]               o_radr2,
  output logic [5:0]               o_waddr,
  output logic [11:0]              o_csr_addr,
  output logic [XLEN-1:0]          o_imm,
  output logic                     o_memop_load,
  output logic                     o_memop_store,
  output logic                     o_memop_sign_ext,
  output logic [1:0]               o_memop_size,
  output logic                     o_rv32,
  output logic                     o_unimplemented,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [4:0] {
    OP_LOAD     = 5'h00, OP_LOAD_FP  = 5'h01, OP_MISC_MEM = 5'h03, OP_IMM    = 5'h04,
    OP_AUIPC    = 5'h05, OP_IMM_32   = 5'h06, OP_STORE    = 5'h08, OP_STORE_FP = 5'h09,
    OP_AMO      = 5'h0B, OP_OP       = 5'h0C, OP_LUI      = 5'h0D, OP_OP_32  = 5'h0E,
    OP_FP       = 5'h14, OP_BRANCH   = 5'h18, OP_JALR     = 5'h19, OP_JAL    = 5'h1B,
    OP_SYSTEM   = 5'h1C
  } opcode_e;

  typedef enum logic [1:0] {MEMOP_1B = 2'd0, MEMOP_2B = 2'd1, MEMOP_4B = 2'd2, MEMOP_8B = 2'd3} memop_size_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      opcode;
    logic [5:0]      radr1;
    logic [5:0]      radr2;
    logic [5:0]      waddr;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] imm;
    logic            memop_load;
    logic            memop_store;
    logic            memop_sign_ext;
    memop_size_e     memop_size;
    logic            rv32;
    logic            unimplemented;
  } entry_t;

  logic [4:0]    w_op;
  logic [2:0]    w_f3;
  logic [4:0]    w_rd, w_rs1, w_rs2;
  logic          w_known, w_rv64_only, w_illegal;
  logic [31:0]   w_imm32;
  entry_t        w_dec;
  entry_t        w_out;
  logic          w_bypass, w_push, w_pop;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  assign w_op  = i_instr[6:2];
  assign w_f3  = i_instr[14:12];
  assign w_rd  = i_instr[11:7];
  assign w_rs1 = i_instr[19:15];
  assign w_rs2 = i_instr[24:20];

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_known = 1'b0;
    case (w_op)
      OP_LOAD, OP_LOAD_FP, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_IMM_32, OP_STORE, OP_STORE_FP,
      OP_AMO, OP_OP, OP_LUI, OP_OP_32, OP_FP, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: w_known = 1'b1;
      default: w_known = 1'b0;
    endcase
  end

  assign w_rv64_only = (w_op == OP_IMM_32) || (w_op == OP_OP_32) ||
                       ((w_op == OP_LOAD) && ((w_f3 == 3'd3) || (w_f3 == 3'd6))) ||
                       ((w_op == OP_STORE) && (w_f3 == 3'd3));
  assign w_illegal   = (i_instr[1:0] != 2'b11) || !w_known || ((XLEN == 32) && w_rv64_only);

  always_comb begin
    w_imm32 = '0;
    case (w_op)
      OP_LOAD, OP_LOAD_FP, OP_IMM, OP_IMM_32, OP_JALR:
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      OP_STORE, OP_STORE_FP:
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OP_BRANCH:
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm32 = {i_instr[31:12], 12'b0};
      OP_JAL:
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Bit 5 of a register field selects the FP register file.
  always_comb begin
    w_dec            = '0;
    w_dec.pc         = i_pc;
    w_dec.instr      = i_instr;
    w_dec.opcode     = w_op;
    w_dec.memop_size = MEMOP_1B;
    if (w_illegal) begin
      w_dec.unimplemented = 1'b1;
    end else begin
      if ((w_op != OP_LUI) && (w_op != OP_AUIPC) && (w_op != OP_JAL))
        w_dec.radr1 = {(w_op == OP_FP), w_rs1};
      if ((w_op == OP_STORE) || (w_op == OP_STORE_FP) || (w_op == OP_BRANCH) || (w_op == OP_OP) ||
          (w_op == OP_OP_32) || (w_op == OP_AMO) || (w_op == OP_FP))
        w_dec.radr2 = {(w_op == OP_STORE_FP) || (w_op == OP_FP), w_rs2};
      if ((w_op != OP_STORE) && (w_op != OP_STORE_FP) && (w_op != OP_BRANCH) && (w_op != OP_MISC_MEM))
        w_dec.waddr = {(w_op == OP_LOAD_FP) || (w_op == OP_FP), w_rd};
      w_dec.csr_addr       = i_instr[31:20];
      w_dec.imm            = XLEN'($signed(w_imm32));
      w_dec.memop_load     = (w_op == OP_LOAD) || (w_op == OP_LOAD_FP);
      w_dec.memop_store    = (w_op == OP_STORE) || (w_op == OP_STORE_FP);
      w_dec.memop_sign_ext = w_dec.memop_load && !w_f3[2];
      w_dec.memop_size     = memop_size_e'(w_f3[1:0]);
      w_dec.rv32           = (w_op == OP_IMM_32) || (w_op == OP_OP_32);
    end
  end

`ifdef DEC_RV_QUEUE_BYPASS_EN
  assign w_bypass = (r_count == '0) && i_valid && !i_flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign o_ready = (r_count < CW'(DEPTH));
  assign o_valid = (r_count != '0) || w_bypass;
  // A bypassed instruction consumed the same cycle never occupies a slot.
  assign w_push  = i_valid && o_ready && !i_flush && !(w_bypass && i_ready);
  assign w_pop   = (r_count != '0) && i_ready && !i_flush;

  // NOTE: entry storage has no reset; r_count alone decides which slots hold live data.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_out            = '0;
    w_out.pc         = '1;
    w_out.instr      = '1;
    w_out.memop_size = MEMOP_1B;
    if (o_valid) w_out = w_bypass ? w_dec : r_mem[r_rd_ptr];
  end

  assign o_pc             = w_out.pc;
  assign o_instr          = w_out.instr;
  assign o_opcode         = w_out.opcode;
  assign o_radr1          = w_out.radr1;
  assign o_radr2          = w_out.radr2;
  assign o_waddr          = w_out.waddr;
  assign o_csr_addr       = w_out.csr_addr;
  assign o_imm            = w_out.imm;
  assign o_memop_load     = w_out.memop_load;
  assign o_memop_store    = w_out.memop_store;
  assign o_memop_sign_ext = w_out.memop_sign_ext;
  assign o_memop_size     = w_out.memop_size;
  assign o_rv32           = w_out.rv32;
  assign o_unimplemented  = w_out.unimplemented;
  assign o_count          = r_count;

endmodule

// File: tb/tb_dec_rv_queue.sv
// Bench for dec_rv_queue: an RV64/DEPTH=2 and an RV32/DEPTH=4 instance share random stimulus
// and are compared every cycle against a queue-based reference model.
module tb_dec_rv_queue;

`ifdef DEC_RV_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  opcode;
    logic [5:0]  radr1, radr2, waddr;
    logic [11:0] csr;
    logic [63:0] imm;
    logic        load, store, sext;
    logic [1:0]  size;
    logic        rv32, unimpl;
  } ent_t;
  typedef ent_t ent_q_t[$];

  logic        clk = 1'b0;
  logic        nrst, flush, valid, ready;
  logic [63:0] pc;
  logic [31:0] instr;
  bit          cmp_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  ent_q_t      q64, q32;
  bit [4:0]    known_ops [17] = '{5'h00, 5'h01, 5'h03, 5'h04, 5'h05, 5'h06, 5'h08, 5'h09, 5'h0B,
                                  5'h0C, 5'h0D, 5'h0E, 5'h14, 5'h18, 5'h19, 5'h1B, 5'h1C};

  logic        o64_ready, o64_valid, o64_load, o64_store, o64_sext, o64_rv32, o64_unimpl;
  logic [63:0] o64_pc, o64_imm;
  logic [31:0] o64_instr;
  logic [4:0]  o64_opcode;
  logic [5:0]  o64_radr1, o64_radr2, o64_waddr;
  logic [11:0] o64_csr;
  logic [1:0]  o64_size, o64_count;

  logic        o32_ready, o32_valid, o32_load, o32_store, o32_sext, o32_rv32, o32_unimpl;
  logic [31:0] o32_pc, o32_imm;
  logic [31:0] o32_instr;
  logic [4:0]  o32_opcode;
  logic [5:0]  o32_radr1, o32_radr2, o32_waddr;
  logic [11:0] o32_csr;
  logic [1:0]  o32_size;
  logic [2:0]  o32_count;

  dec_rv_queue #(.XLEN(64), .DEPTH(2)) u64 (
    .i_clk(clk), .i_nrst(nrst), .i_flush(flush), .i_valid(valid), .o_ready(o64_ready),
    .i_pc(pc), .i_instr(instr), .o_valid(o64_valid), .i_ready(ready), .o_pc(o64_pc),
    .o_instr(o64_instr), .o_opcode(o64_opcode), .o_radr1(o64_radr1), .o_radr2(o64_radr2),
    .o_waddr(o64_waddr), .o_csr_addr(o64_csr), .o_imm(o64_imm), .o_memop_load(o64_load),
    .o_memop_store(o64_store), .o_memop_sign_ext(o64_sext), .o_memop_size(o64_size),
    .o_rv32(o64_rv32), .o_unimplemented(o64_unimpl), .o_count(o64_count));

  dec_rv_queue #(.XLEN(32), .DEPTH(4)) u32 (
    .i_clk(clk), .i_nrst(nrst), .i_flush(flush), .i_valid(valid), .o_ready(o32_ready),
    .i_pc(pc[31:0]), .i_instr(instr), .o_valid(o32_valid), .i_ready(ready), .o_pc(o32_pc),
    .o_instr(o32_instr), .o_opcode(o32_opcode), .o_radr1(o32_radr1), .o_radr2(o32_radr2),
    .o_waddr(o32_waddr), .o_csr_addr(o32_csr), .o_imm(o32_imm), .o_memop_load(o32_load),
    .o_memop_store(o32_store), .o_memop_sign_ext(o32_sext), .o_memop_size(o32_size),
    .o_rv32(o32_rv32), .o_unimplemented(o32_unimpl), .o_count(o32_count));

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value of the low 'bits' bits of v read as two's complement.
  function automatic longint sx(input logic [31:0] v, input int bits);
    longint x;
    x = longint'(v);
    if (v[bits-1]) x = x - (longint'(1) <<< bits);
    return x;
  endfunction

  function automatic ent_t idle_ent(input int xlen);
    ent_t e;
    e = '{default: '0};
    e.pc    = (xlen == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    e.instr = 32'hFFFF_FFFF;
    return e;
  endfunction

  function automatic ent_t decode(input int xlen, input logic [63:0] p, input logic [31:0] ins);
    ent_t        e;
    logic [63:0] m;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [31:0] raw;
    longint      v;
    bit          bad32;
    m  = (xlen == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    op = ins[6:2];
    f3 = ins[14:12];
    e  = '{default: '0};
    e.pc = p & m; e.instr = ins; e.opcode = op;
    bad32 = (xlen == 32) && (op == 5'h06 || op == 5'h0E || (op == 5'h00 && (f3 == 3 || f3 == 6)) ||
                             (op == 5'h08 && f3 == 3));
    if (ins[1:0] != 2'b11 || !(op inside {5'h00, 5'h01, 5'h03, 5'h04, 5'h05, 5'h06, 5'h08, 5'h09, 5'h0B,
        5'h0C, 5'h0D, 5'h0E, 5'h14, 5'h18, 5'h19, 5'h1B, 5'h1C}) || bad32) begin
      e.unimpl = 1'b1;
      return e;
    end
    v = 0;
    case (op)
      5'h00, 5'h01, 5'h04, 5'h06, 5'h19: v = sx(32'(ins[31:20]), 12);
      5'h08, 5'h09: v = sx(ins[31:25] * 32 + 32'(ins[11:7]), 12);
      5'h18: begin
        raw = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
        v = sx(raw, 13);
      end
      5'h0D, 5'h05: v = sx(ins & 32'hFFFF_F000, 32);
      5'h1B: begin
        raw = ins[31] * (1 << 20) + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
        v = sx(raw, 21);
      end
      default: v = 0;
    endcase
    e.imm   = 64'(v) & m;
    e.radr1 = (op inside {5'h0D, 5'h05, 5'h1B}) ? 6'd0 : 6'(ins[19:15]) + ((op == 5'h14) ? 6'd32 : 6'd0);
    e.radr2 = (op inside {5'h08, 5'h09, 5'h18, 5'h0C, 5'h0E, 5'h0B, 5'h14}) ?
              6'(ins[24:20]) + ((op == 5'h09 || op == 5'h14) ? 6'd32 : 6'd0) : 6'd0;
    e.waddr = (op inside {5'h08, 5'h09, 5'h18, 5'h03}) ? 6'd0 :
              6'(ins[11:7]) + ((op == 5'h01 || op == 5'h14) ? 6'd32 : 6'd0);
    e.csr   = ins[31:20];
    e.load  = (op == 5'h00 || op == 5'h01);
    e.store = (op == 5'h08 || op == 5'h09);
    e.size  = f3[1:0];
    e.sext  = e.load && !f3[2];
    e.rv32  = (op == 5'h06 || op == 5'h0E);
    return e;
  endfunction

  function automatic ent_t exp_head(input ent_q_t q, input int xlen, output bit v);
    if (q.size() > 0) begin
      v = 1'b1;
      return q[0];
    end
    if (BYP && valid && !flush) begin
      v = 1'b1;
      return decode(xlen, pc, instr);
    end
    v = 1'b0;
    return idle_ent(xlen);
  endfunction

  function automatic ent_q_t step(input ent_q_t q, input int depth, input int xlen);
    bit byp, do_pop, do_push;
    ent_q_t r;
    r = q;
    if (flush) begin
      r.delete();
      return r;
    end
    byp     = BYP && (r.size() == 0) && valid;
    do_pop  = (r.size() != 0) && ready;
    do_push = valid && (r.size() < depth) && !(byp && ready);
    if (do_pop) void'(r.pop_front());
    if (do_push) r.push_back(decode(xlen, pc, instr));
    return r;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q64.delete();
      q32.delete();
    end else begin
      q64 = step(q64, 2, 64);
      q32 = step(q32, 4, 32);
    end
  end

  task automatic cmp_ent(input string t, input ent_t e, input ent_t a);
    check({t, ".pc"}, a.pc, e.pc);
    check({t, ".instr"}, 64'(a.instr), 64'(e.instr));
    check({t, ".opcode"}, 64'(a.opcode), 64'(e.opcode));
    check({t, ".radr1"}, 64'(a.radr1), 64'(e.radr1));
    check({t, ".radr2"}, 64'(a.radr2), 64'(e.radr2));
    check({t, ".waddr"}, 64'(a.waddr), 64'(e.waddr));
    check({t, ".csr"}, 64'(a.csr), 64'(e.csr));
    check({t, ".imm"}, a.imm, e.imm);
    check({t, ".flags"}, {58'd0, a.load, a.store, a.sext, a.rv32, a.unimpl, 1'b0},
                         {58'd0, e.load, e.store, e.sext, e.rv32, e.unimpl, 1'b0});
    check({t, ".size"}, 64'(a.size), 64'(e.size));
  endtask

  always @(negedge clk) begin
    ent_t e, a;
    bit   v;
    if (cmp_en) begin
      e = exp_head(q64, 64, v);
      a = '{pc: o64_pc, instr: o64_instr, opcode: o64_opcode, radr1: o64_radr1, radr2: o64_radr2,
            waddr: o64_waddr, csr: o64_csr, imm: o64_imm, load: o64_load, store: o64_store,
            sext: o64_sext, size: o64_size, rv32: o64_rv32, unimpl: o64_unimpl};
      check("u64.valid", 64'(o64_valid), 64'(v));
      check("u64.ready", 64'(o64_ready), 64'(q64.size() < 2));
      check("u64.count", 64'(o64_count), 64'(q64.size()));
      cmp_ent("u64", e, a);
      e = exp_head(q32, 32, v);
      a = '{pc: 64'(o32_pc), instr: o32_instr, opcode: o32_opcode, radr1: o32_radr1, radr2: o32_radr2,
            waddr: o32_waddr, csr: o32_csr, imm: 64'(o32_imm), load: o32_load, store: o32_store,
            sext: o32_sext, size: o32_size, rv32: o32_rv32, unimpl: o32_unimpl};
      check("u32.valid", 64'(o32_valid), 64'(v));
      check("u32.ready", 64'(o32_ready), 64'(q32.size() < 4));
      check("u32.count", 64'(o32_count), 64'(q32.size()));
      cmp_ent("u32", e, a);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    r[6:2] = ($urandom_range(0, 99) < 90) ? known_ops[$urandom_range(0, 16)] : 5'($urandom);
    r[1:0] = ($urandom_range(0, 99) < 95) ? 2'b11 : 2'($urandom_range(0, 2));
    return r;
  endfunction

  initial begin
    nrst = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0; pc = '0; instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.valid", 64'(o64_valid), 64'd0);
    check("rst.count", 64'(o64_count), 64'd0);
    check("rst.pc", o64_pc, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst.instr", 64'(o64_instr), 64'hFFFF_FFFF);
    check("rst.size", 64'(o64_size), 64'd0);
    check("rst.pc32", 64'(o32_pc), 64'hFFFF_FFFF);
    #1 nrst = 1'b1;
    cmp_en = 1'b1;
    cyc();

    // addi x1,x2,-1 at 0x100: registered path shows it one cycle later
    valid = 1'b1; pc = 64'h100; instr = 32'hFFF1_0093; ready = 1'b0;
    @(negedge clk);
    check("lat.same_cycle_valid", 64'(o64_valid), 64'(BYP));
    cyc(); valid = 1'b0;
    @(negedge clk);
    check("addi.valid", 64'(o64_valid), 64'd1);
    check("addi.opcode", 64'(o64_opcode), 64'h04);
    check("addi.radr1", 64'(o64_radr1), 64'd2);
    check("addi.waddr", 64'(o64_waddr), 64'd1);
    check("addi.imm", o64_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi.unimpl", 64'(o64_unimpl), 64'd0);
    check("addi.imm32", 64'(o32_imm), 64'hFFFF_FFFF);
    check("addi.pc", o64_pc, 64'h100);
    flush = 1'b1; cyc(); flush = 1'b0;
    @(negedge clk);
    check("flush.count", 64'(o64_count), 64'd0);

    // fill a DEPTH=2 queue with three pushes while the consumer stalls
    valid = 1'b1; ready = 1'b0;
    instr = 32'h0050_0093; pc = 64'h200; cyc();
    instr = 32'h0020_8133; pc = 64'h204; cyc();
    instr = 32'h00A0_0193; pc = 64'h208;
    @(negedge clk);
    check("full.ready", 64'(o64_ready), 64'd0);
    check("full.count", 64'(o64_count), 64'd2);
    check("full.head", 64'(o64_instr), 64'h0050_0093);
    cyc();
    @(negedge clk);
    check("full.held_count", 64'(o64_count), 64'd2);
    ready = 1'b1; cyc();
    @(negedge clk);
    check("drain1.head", 64'(o64_instr), 64'h0020_8133);
    check("drain1.count", 64'(o64_count), 64'd1);
    check("drain1.ready", 64'(o64_ready), 64'd1);
    cyc(); valid = 1'b0;
    @(negedge clk);
    check("drain2.head", 64'(o64_instr), 64'h00A0_0193);
    check("drain2.pc", o64_pc, 64'h208);
    cyc();
    @(negedge clk);
    check("drain3.valid", 64'(o64_valid), 64'd0);

    // flush beats a simultaneous push and pop
    valid = 1'b1; ready = 1'b0;
    instr = 32'h0050_0093; cyc();
    instr = 32'h0020_8133; cyc();
    instr = 32'h00A0_0193; ready = 1'b1; flush = 1'b1; cyc();
    flush = 1'b0; valid = 1'b0; ready = 1'b0;
    @(negedge clk);
    check("flushpp.count", 64'(o64_count), 64'd0);
    check("flushpp.valid", 64'(o64_valid), 64'd0);

    // ld is RV64-only, lw is legal on both
    valid = 1'b1; pc = 64'h300; instr = 32'h0001_3083; cyc();
    instr = 32'h0001_2083; pc = 64'h304; cyc(); valid = 1'b0;
    @(negedge clk);
    check("ld32.unimpl", 64'(o32_unimpl), 64'd1);
    check("ld32.load", 64'(o32_load), 64'd0);
    check("ld32.waddr", 64'(o32_waddr), 64'd0);
    check("ld64.size", 64'(o64_size), 64'd3);
    check("ld64.load", 64'(o64_load), 64'd1);
    ready = 1'b1; cyc(); ready = 1'b0;
    @(negedge clk);
    check("lw32.load", 64'(o32_load), 64'd1);
    check("lw32.size", 64'(o32_size), 64'd2);
    check("lw32.sext", 64'(o32_sext), 64'd1);
    flush = 1'b1; cyc(); flush = 1'b0;

`ifdef DEC_RV_QUEUE_BYPASS_EN
    valid = 1'b1; ready = 1'b1; instr = 32'h0000_006F; pc = 64'h400;
    @(negedge clk);
    check("byp.valid", 64'(o64_valid), 64'd1);
    check("byp.opcode", 64'(o64_opcode), 64'h1B);
    check("byp.count", 64'(o64_count), 64'd0);
    cyc(); valid = 1'b0; ready = 1'b0;
    @(negedge clk);
    check("byp.count_after", 64'(o64_count), 64'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 99) < 60);
      ready = ($urandom_range(0, 99) < 50);
      flush = ($urandom_range(0, 99) < 3);
      pc    = {$urandom, $urandom} & ~64'd3;
      instr = rand_instr();
      if (i % 750 == 400) begin
        valid = 1'b0;
        #2 nrst = 1'b0;
        @(negedge clk);
        #1 nrst = 1'b1;
      end
      cyc();
    end

    valid = 1'b0; ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
